// File: rtl/packet_from_transfer.sv
// Receive-side score packet deframer: pops bytes from a FWFT RX FIFO and rebuilds
// {ID, P[23:16], P[15:8], P[7:0]} frames into a registered opponent ID and points value.
module packet_from_transfer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  board_ID,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    output logic        rd_en,
    output logic [7:0]  rx_board_ID,
    output logic [23:0] rx_points,
    output logic        pkt_valid,
    output logic        frame_err,
    output logic [7:0]  pkt_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_ID,
        GET_B2,
        GET_B1,
        GET_B0
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    id_q, id_d;
    logic [23:8]   pts_q, pts_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    rx_board_ID_q, rx_board_ID_d;
    logic [23:0]   rx_points_q, rx_points_d;
    logic          pkt_valid_q, pkt_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    pkt_cnt_q, pkt_cnt_d;

    // The FIFO is never back-pressured: every available byte is consumed this cycle.
    assign rd_en = !rx_empty && !rst;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d       = state_q;
        id_d          = id_q;
        pts_d         = pts_q;
        timer_d       = timer_q;
        rx_board_ID_d = rx_board_ID_q;
        rx_points_d   = rx_points_q;
        pkt_valid_d   = 1'b0;
        frame_err_d   = 1'b0;
        pkt_cnt_d     = pkt_cnt_q;

        if (state_q == WAIT_ID) begin
            timer_d = '0;
            // A zero ID byte is sync filler and never starts a frame.
            if (rd_en && rx_data != 8'h00) begin
                id_d    = rx_data;
                state_d = GET_B2;
            end
        end else if (rd_en) begin
            // A pop always beats a timeout that would fire in the same cycle.
            timer_d = '0;
            unique case (state_q)
                GET_B2: begin
                    pts_d[23:16] = rx_data;
                    state_d      = GET_B1;
                end
                GET_B1: begin
                    pts_d[15:8] = rx_data;
                    state_d     = GET_B0;
                end
                default: begin
                    state_d = WAIT_ID;
                    if (id_q != board_ID) begin
                        rx_board_ID_d = id_q;
                        rx_points_d   = {pts_q, rx_data};
                        pkt_valid_d   = 1'b1;
                        pkt_cnt_d     = pkt_cnt_q + 8'd1;
                    end
                end
            endcase
        end else if (timer_q == TIMER_MAX) begin
            state_d     = WAIT_ID;
            timer_d     = '0;
            frame_err_d = 1'b1;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            state_q       <= WAIT_ID;
            id_q          <= '0;
            pts_q         <= '0;
            timer_q       <= '0;
            rx_board_ID_q <= '0;
            rx_points_q   <= '0;
            pkt_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            pkt_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            id_q          <= id_d;
            pts_q         <= pts_d;
            timer_q       <= timer_d;
            rx_board_ID_q <= rx_board_ID_d;
            rx_points_q   <= rx_points_d;
            pkt_valid_q   <= pkt_valid_d;
            frame_err_q   <= frame_err_d;
            pkt_cnt_q     <= pkt_cnt_d;
        end
    end

    assign rx_board_ID = rx_board_ID_q;
    assign rx_points   = rx_points_q;
    assign pkt_valid   = pkt_valid_q;
    assign frame_err   = frame_err_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_packet_from_transfer.sv
// Scoreboard bench for packet_from_transfer: a byte-queue FIFO model feeds the DUT and
// expected frames are queued at stimulus time, then compared on every pkt_valid pulse.
module tb_packet_from_transfer;

    localparam int TOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  board_ID;
    logic [7:0]  rx_data;
    logic        rx_empty;
    logic        rd_en;
    logic [7:0]  rx_board_ID;
    logic [23:0] rx_points;
    logic        pkt_valid;
    logic        frame_err;
    logic [7:0]  pkt_cnt;

    typedef struct packed {
        logic [7:0]  id;
        logic [23:0] pts;
        logic [7:0]  cnt;
    } exp_t;

    logic [7:0] fifo_q[$];
    exp_t       exp_q[$];
    logic [7:0] model_cnt;
    int         errors = 0;
    int         checks = 0;
    int         ferr_seen = 0;
    int         ferr_exp = 0;
    int         cyc = 0;
    int         last_cyc = -1;
    bit         chk_spacing = 1'b0;

    packet_from_transfer #(.TIMEOUT_CYCLES(TOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .board_ID   (board_ID),
        .rx_data    (rx_data),
        .rx_empty   (rx_empty),
        .rd_en      (rd_en),
        .rx_board_ID(rx_board_ID),
        .rx_points  (rx_points),
        .pkt_valid  (pkt_valid),
        .frame_err  (frame_err),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // FWFT FIFO model: head presented on negedge, popped at the posedge where rd_en was high.
    initial begin
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            rx_empty = (fifo_q.size() == 0);
            rx_data  = rx_empty ? 8'h00 : fifo_q[0];
            @(posedge clk);
            if (!rx_empty && !rst) void'(fifo_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pkt_valid || frame_err) check("excl", {31'd0, pkt_valid && frame_err}, 32'd0);
            if (frame_err) ferr_seen++;
            if (pkt_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pkt", {24'd0, rx_board_ID}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rx_board_ID", {24'd0, rx_board_ID}, {24'd0, e.id});
                    check("rx_points", {8'd0, rx_points}, {8'd0, e.pts});
                    check("pkt_cnt", {24'd0, pkt_cnt}, {24'd0, e.cnt});
                end
                if (chk_spacing && last_cyc >= 0) check("spacing", cyc - last_cyc, 32'd4);
                last_cyc = cyc;
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_q.size() != 0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (fifo_q.size() != 0) check("drain_timeout", fifo_q.size(), 32'd0);
    endtask

    task automatic add_exp(input logic [7:0] id, input logic [23:0] pts);
        exp_t e;
        model_cnt = model_cnt + 8'd1;
        e.id  = id;
        e.pts = pts;
        e.cnt = model_cnt;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [23:0] pts);
        fifo_q.push_back(id);
        fifo_q.push_back(pts[23:16]);
        fifo_q.push_back(pts[15:8]);
        fifo_q.push_back(pts[7:0]);
        if (id != board_ID) add_exp(id, pts);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_cnt = 8'd0;
        exp_q.delete();
        settle(2);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        @(negedge clk);
        check("rst_id", {24'd0, rx_board_ID}, 32'd0);
        check("rst_pts", {8'd0, rx_points}, 32'd0);
        check("rst_cnt", {24'd0, pkt_cnt}, 32'd0);
        check("rst_pulses", {30'd0, pkt_valid, frame_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        board_ID = 8'h01;
        model_cnt = 8'd0;
        do_reset();

        // Basic frame, then zero filler before a frame.
        send_frame(8'h02, 24'h123456);
        drain(); settle(3);
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'h00);
        send_frame(8'h03, 24'hABCDEF);
        drain(); settle(3);

        // Frame carrying the local ID is dropped silently.
        board_ID = 8'h05;
        send_frame(8'h05, 24'h112233);
        drain(); settle(3);
        check("drop_id", {24'd0, rx_board_ID}, 32'h03);
        check("drop_pts", {8'd0, rx_points}, 32'h00ABCDEF);
        check("drop_cnt", {24'd0, pkt_cnt}, 32'd2);

        // Last byte arrives in the timeout cycle itself: the pop wins.
        fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h11);
        drain();
        repeat (TOUT - 1) @(posedge clk);
        #1;
        fifo_q.push_back(8'h22);
        add_exp(8'h02, 24'h1122AA);
        drain();
        repeat (TOUT - 1) @(posedge clk);
        #1;
        fifo_q.push_back(8'hAA);
        drain(); settle(3);
        check("no_ferr", ferr_seen, ferr_exp);

        // Full idle window aborts the partial frame.
        fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h11);
        drain();
        repeat (TOUT) @(posedge clk);
        #1;
        ferr_exp++;
        settle(2);
        check("ferr", ferr_seen, ferr_exp);
        send_frame(8'h04, 24'h000007);
        drain(); settle(3);

        // Reset mid-frame discards partial bytes.
        fifo_q.push_back(8'h09);
        fifo_q.push_back(8'hAA);
        drain();
        do_reset();
        send_frame(8'h06, 24'h010203);
        drain(); settle(3);
        check("post_rst_cnt", {24'd0, pkt_cnt}, 32'd1);

        // Back-to-back frames with the FIFO never empty, then counter wrap.
        do_reset();
        chk_spacing = 1'b1;
        last_cyc = -1;
        for (int i = 0; i < 3; i++) send_frame(8'h10 + 8'(i), 24'(32'h00_0100 * (i + 1)));
        drain(); settle(3);
        check("b2b_cnt", {24'd0, pkt_cnt}, 32'd3);
        last_cyc = -1;
        for (int i = 0; i < 253; i++) send_frame(8'h20 + 8'(i % 16), 24'($urandom));
        drain(); settle(3);
        check("wrap_cnt", {24'd0, pkt_cnt}, 32'd0);
        chk_spacing = 1'b0;

        check("sb_empty", exp_q.size(), 32'd0);
        check("ferr_total", ferr_seen, ferr_exp);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
